// File: rtl/store_merge.sv
// Store path to a byte-enable-less, word-wide data memory: word stores write directly,
// byte/halfword stores do read-modify-write. Optional macro STORE_ALIGN_TRAP_EN traps misaligned sh/sw.
module store_merge #(
    parameter int MEM_AW = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              StReq,
    input  logic [31:0]       StAdr,
    input  logic [31:0]       StData,
    input  logic [1:0]        Bytes2Store,
    output logic              Busy,
    output logic              StDone,
    output logic              AlignErr,
    output logic [MEM_AW-1:0] MemAddr,
    output logic              MemRdEn,
    input  logic [31:0]       MemRdData,
    output logic              MemWrEn,
    output logic [31:0]       MemWrData
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    state_e              state_q, state_d;
    logic [MEM_AW+1:0]   adr_q, adr_d;
    logic [31:0]         data_q, data_d;
    logic [1:0]          size_q, size_d;
    logic                err_q, err_d;
    logic                busy_q, rd_en_q, wr_en_q, done_q;
    logic                mis_s;
    logic                sub_word_s;
    logic                unused_s;

    // Replace the addressed lane(s) of word; anything that is not sb/sh is a full-word store.
    function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    2'd3:    res[31:24] = data[7:0];
                    default: res        = word;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    res[31:16] = data[15:0];
                end else begin
                    res[15:0]  = data[15:0];
                end
            end
            default: res = data;
        endcase
        return res;
    endfunction

`ifdef STORE_ALIGN_TRAP_EN
    logic align_q;

    // sh must be halfword aligned and sw word aligned; sb can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic res;
        case (size)
            SZ_BYTE: res = 1'b0;
            SZ_HALF: res = lane[0];
            default: res = (lane != 2'd0);
        endcase
        return res;
    endfunction

    assign mis_s    = is_misaligned(Bytes2Store, StAdr[1:0]);
    assign AlignErr = align_q;
`else
    assign mis_s    = 1'b0;
    assign AlignErr = 1'b0;
`endif

    assign sub_word_s = (Bytes2Store == SZ_BYTE) || (Bytes2Store == SZ_HALF);
    assign unused_s   = ^StAdr[31:MEM_AW+2];

    // Next-state and request latching; a request is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        data_d  = data_q;
        size_d  = size_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (StReq) begin
                    adr_d  = StAdr[MEM_AW+1:0];
                    data_d = StData;
                    size_d = Bytes2Store;
                    err_d  = mis_s;
                    // A trapped request skips the read; it only needs the WRITE slot to flag the error.
                    if (sub_word_s && !mis_s) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            data_q  <= 32'h0000_0000;
            size_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            err_q   <= err_d;
        end
    end

    // Moore control outputs, registered from the next state so they line up with state_q.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q  <= (state_d != ST_IDLE);
            rd_en_q <= (state_d == ST_READ);
            wr_en_q <= (state_d == ST_WRITE) && !err_d;
            done_q  <= (state_d == ST_WRITE) && !err_d;
        end
    end

`ifdef STORE_ALIGN_TRAP_EN
    // Misalignment pulse occupies the WRITE slot in place of the memory write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            align_q <= 1'b0;
        end else begin
            align_q <= (state_d == ST_WRITE) && err_d;
        end
    end
`endif

    // Write data: sub-word stores merge straight from the read data returned in WRITE.
    always_comb begin
        MemWrData = 32'h0000_0000;
        if (state_q == ST_WRITE) begin
            MemWrData = merge_lanes(MemRdData, data_q, size_q, adr_q[1:0]);
        end else begin
            MemWrData = 32'h0000_0000;
        end
    end

    assign Busy    = busy_q;
    assign StDone  = done_q;
    assign MemRdEn = rd_en_q;
    assign MemWrEn = wr_en_q;
    assign MemAddr = adr_q[MEM_AW+1:2];

endmodule

// File: tb/tb_store_merge.sv
// Self-checking bench for store_merge: directed cases plus random stores against a word-array reference.
module tb_store_merge;

    localparam int AW    = 10;
    localparam int WORDS = 1 << AW;

    logic          Clk;
    logic          Reset_n;
    logic          StReq;
    logic [31:0]   StAdr;
    logic [31:0]   StData;
    logic [1:0]    Bytes2Store;
    logic          Busy;
    logic          StDone;
    logic          AlignErr;
    logic [AW-1:0] MemAddr;
    logic          MemRdEn;
    logic [31:0]   MemRdData;
    logic          MemWrEn;
    logic [31:0]   MemWrData;

    logic [31:0]   mem     [WORDS];
    logic [31:0]   ref_mem [WORDS];
    int            wr_count;
    int            rd_count;
    int            n_checks;
    int            n_errors;

    store_merge #(.MEM_AW(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .StReq(StReq), .StAdr(StAdr), .StData(StData),
        .Bytes2Store(Bytes2Store), .Busy(Busy), .StDone(StDone), .AlignErr(AlignErr),
        .MemAddr(MemAddr), .MemRdEn(MemRdEn), .MemRdData(MemRdData),
        .MemWrEn(MemWrEn), .MemWrData(MemWrData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous single-port memory: read data appears the cycle after MemRdEn.
    always @(posedge Clk) begin
        if (MemRdEn) begin
            MemRdData <= mem[MemAddr];
            rd_count  <= rd_count + 1;
        end
        if (MemWrEn) begin
            mem[MemAddr] <= MemWrData;
            wr_count     <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result of a store: plain mask-and-shift on the whole word.
    function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] mask;
        int          sh;
        if (sz == 2'd1) begin
            sh   = 8 * int'(adr[1:0]);
            mask = 32'h0000_00FF << sh;
            return (word & ~mask) | ((dat & 32'h0000_00FF) << sh);
        end else if (sz == 2'd2) begin
            sh   = adr[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
            return (word & ~mask) | ((dat & 32'h0000_FFFF) << sh);
        end
        return dat;
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] adr);
`ifdef STORE_ALIGN_TRAP_EN
        if (sz == 2'd2) return adr[0];
        if (sz != 2'd1) return adr[1:0] != 2'd0;
`endif
        return 1'b0;
    endfunction

    // Issue one store from an idle DUT at a negedge and check it cycle by cycle.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] adr, input logic [31:0] dat);
        int          widx;
        bit          sub;
        bit          mis;
        logic [31:0] exp_word;
        widx     = int'(adr[AW+1:2]);
        sub      = (sz == 2'd1) || (sz == 2'd2);
        mis      = ref_misaligned(sz, adr);
        exp_word = ref_merge(ref_mem[widx], sz, adr, dat);
        StReq = 1'b1; StAdr = adr; StData = dat; Bytes2Store = sz;
        @(negedge Clk);
        StReq = 1'b0;
        check("busy_first", Busy, 1);
        check("mem_addr", MemAddr, widx);
        if (sub && !mis) begin
            check("read_en", MemRdEn, 1);
            check("no_wr_in_read", MemWrEn, 0);
            @(negedge Clk);
            check("addr_stable", MemAddr, widx);
        end else begin
            check("no_read", MemRdEn, 0);
        end
        check("write_en", MemWrEn, !mis);
        check("st_done", StDone, !mis);
        check("align_err", AlignErr, mis);
        check("no_rd_in_write", MemRdEn, 0);
        if (!mis) begin
            check("wr_data", MemWrData, exp_word);
            ref_mem[widx] = exp_word;
        end
        @(negedge Clk);
        check("busy_low", Busy, 0);
        check("mem_word", mem[widx], ref_mem[widx]);
    endtask

    initial begin
        int wc;
        int rc;
        n_checks = 0; n_errors = 0; wr_count = 0; rd_count = 0;
        MemRdData = 32'h0;
        StReq = 1'b0; StAdr = 32'h0; StData = 32'h0; Bytes2Store = 2'd0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;

        Reset_n = 1'b0;
        #12;
        check("rst_busy", Busy, 0);
        check("rst_done", StDone, 0);
        check("rst_rd", MemRdEn, 0);
        check("rst_wr", MemWrEn, 0);
        check("rst_addr", MemAddr, 0);
        check("rst_align", AlignErr, 0);
        check("rst_wdata", MemWrData, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Directed cases from the block's worked examples.
        run_store(2'd1, 32'h12, 32'hFFFF_FFAA);
        check("sb_result", mem[4], 32'h11AA_3344);
        mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        run_store(2'd2, 32'h12, 32'h0000_BEEF);
        check("sh_hi_result", mem[4], 32'hBEEF_3344);
        mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        run_store(2'd2, 32'h10, 32'h0000_BEEF);
        check("sh_lo_result", mem[4], 32'h1122_BEEF);
        rc = rd_count;
        run_store(2'd0, 32'h14, 32'hDEAD_BEEF);
        check("sw_result", mem[5], 32'hDEAD_BEEF);
        check("sw_no_read", rd_count, rc);

        // Held request: the second sb must wait for Busy to fall; mid-flight changes are ignored.
        mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        StReq = 1'b1; StAdr = 32'h10; StData = 32'h0000_00AA; Bytes2Store = 2'd1;
        @(negedge Clk);
        StAdr = 32'h11; StData = 32'h0000_00BB;
        check("b2b_read1", MemRdEn, 1);
        @(negedge Clk);
        check("b2b_wdata1", MemWrData, 32'h1122_33AA);
        @(negedge Clk);
        check("b2b_gap", Busy, 0);
        @(negedge Clk);
        StReq = 1'b0;
        check("b2b_busy2", Busy, 1);
        check("b2b_read2", MemRdEn, 1);
        @(negedge Clk);
        check("b2b_wr2", MemWrEn, 1);
        @(negedge Clk);
        check("b2b_final", mem[4], 32'h1122_BBAA);
        ref_mem[4] = 32'h1122_BBAA;

        // Reset during the READ of an sb: nothing may be written.
        mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        StReq = 1'b1; StAdr = 32'h12; StData = 32'h0000_00AA; Bytes2Store = 2'd1;
        @(negedge Clk);
        StReq = 1'b0;
        check("rr_in_read", MemRdEn, 1);
        wc = wr_count;
        Reset_n = 1'b0;
        #1;
        check("rr_busy", Busy, 0);
        check("rr_rd", MemRdEn, 0);
        check("rr_wr", MemWrEn, 0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        check("rr_no_write", wr_count, wc);
        check("rr_word", mem[4], 32'h1122_3344);

        // Misaligned word store: trapped with the macro, plain write of word 4 without.
        mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        run_store(2'd0, 32'h13, 32'h5555_AAAA);
`ifdef STORE_ALIGN_TRAP_EN
        check("trap_word", mem[4], 32'h1122_3344);
`else
        check("sw_unaligned", mem[4], 32'h5555_AAAA);
`endif

        // Random stores over a small address window against the reference array.
        for (int k = 0; k < 60; k++) begin
            run_store(2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom);
        end
        for (int i = 0; i < 16; i++) begin
            check("final_mem", mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/store_merge.md
# store_merge

Store-side counterpart of the load masking path. Accepts sb/sh/sw requests from the MEM stage and drives a single-port, word-wide data memory that has no byte enables. Word stores are written directly. Byte and halfword stores go through a read-modify-write sequence that merges the new lane(s) into the existing word. `Busy` stalls the pipeline while a store is in flight.

## Interface
- `MEM_AW`, default 10: word-address width of the data memory.
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `StReq`  in  1  store request, sampled only in IDLE.
- `StAdr`  in  32  byte address of the store.
- `StData`  in  32  store data; byte/half taken from the low bits.
- `Bytes2Store`  in  2  2 = sh, 1 = sb, other = sw.
- `Busy`  out  1  high whenever state is not IDLE.
- `StDone`  out  1  one-cycle pulse in the cycle the memory write is issued.
- `AlignErr`  out  1  misalignment pulse; only exists with the macro, otherwise tied to 0.
- `MemAddr`  out  MEM_AW  word address, equal to `StAdr[MEM_AW+1:2]` (latched).
- `MemRdEn`  out  1  memory read strobe.
- `MemRdData`  in  32  memory read data, valid the cycle after `MemRdEn`.
- `MemWrEn`  out  1  memory write strobe.
- `MemWrData`  out  32  word to write.

## Operation
- States: IDLE, READ, WRITE.
- **IDLE**
  - On `StReq`=1, latch the address, data and size.
  - Sub-word request: go to READ.
  - Word request: go to WRITE.
  - `StReq`=0: stay in IDLE.
- **READ**
  - Drive `MemRdEn`=1 and `MemAddr`.
  - Next state is WRITE.
- **WRITE**
  - Drive `MemWrEn`=1 and `StDone`=1, then return to IDLE.
  - `MemWrData` for sw: the latched `StData`.
  - `MemWrData` for sb/sh: `MemRdData` with the target lane(s) replaced.
- Lane mapping is little-endian: byte n occupies bits [8n+7:8n].
  - sb: lane = `StAdr[1:0]`; data = `StData[7:0]`.
  - sh: `StAdr[1]`=0 selects bits [15:0], 1 selects bits [31:16]; data = `StData[15:0]`.
- Requests are never accepted outside IDLE. The requester holds `StReq` until `Busy` is low; the block has no queue.
- `MemRdEn` and `MemWrEn` are never high in the same cycle.
- `MemAddr` is stable from the READ cycle through the WRITE cycle.

## Timing
- Reset values: state IDLE; all outputs 0; latched address, data and size registers 0.
- Outputs are Moore, decoded from state and latched registers. The one exception is `MemWrData` for sub-word stores, which is combinational from `MemRdData` in WRITE.
- Request accepted at edge T:
  - sw: WRITE during cycle T+1; IDLE at T+2.
  - sb/sh: READ during T+1; WRITE during T+2; IDLE at T+3.
- Throughput: one sw per 2 cycles, one sb/sh per 3 cycles.
- `Busy` rises in the cycle after acceptance and falls at the edge that returns to IDLE.
- Reset asserted mid-operation: state goes to IDLE immediately and `MemWrEn`/`MemRdEn` drop asynchronously. The pending store is discarded and memory is never partially written.
- `StReq` changing while `Busy` is high has no effect.

## Configuration
- `STORE_ALIGN_TRAP_EN` defined:
  - Misaligned requests are sh with `StAdr[0]`=1, or sw with `StAdr[1:0]`≠0.
  - A misaligned request still goes to WRITE at T+1, but in that cycle `MemWrEn` and `StDone` stay 0 and `AlignErr` pulses 1.
  - No memory access occurs.
- `STORE_ALIGN_TRAP_EN` undefined:
  - Unused low address bits are ignored: sh uses `StAdr[1]` only, sw uses neither.
  - `AlignErr` is constant 0.

## Test plan
- Memory word 4 = 0x11223344; sb, `StAdr`=0x12, `StData`=0xFFFFFFAA → read word 4 at T+1, write 0x11AA3344 at T+2, `StDone` at T+2.
- Same initial word; sh, `StAdr`=0x12, `StData`=0x0000BEEF → write 0xBEEF3344. With `StAdr`=0x10 → write 0x1122BEEF.
- sw, `StAdr`=0x14, `StData`=0xDEADBEEF → `MemRdEn` never asserted; write 0xDEADBEEF to word 5 at T+1; `Busy` high for exactly 1 cycle.
- `StReq` held high with back-to-back sb to 0x10 then 0x11 → second request accepted only after `Busy` falls; final word 4 = 0x1122BBAA, given first data 0xAA and second 0xBB.
- `Reset_n` pulled low during READ of an sb → no `MemWrEn` ever; word unchanged; `Busy`=0 immediately.
- With `STORE_ALIGN_TRAP_EN`: sw to 0x13 → `AlignErr` pulse, no write, no `StDone`. Without the macro: the same request writes word 4.
